// File: rtl/aftab_trap_pkg.sv
// Shared constants for the AFTAB trap entry/return sequencer: state codes,
// CSR addresses and mstatus bit positions.
package aftab_trap_pkg;

    localparam int TRAP_LEN = 32;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_T_EPC    = 3'd1;
    localparam logic [2:0] S_T_CAUSE  = 3'd2;
    localparam logic [2:0] S_T_TVAL   = 3'd3;
    localparam logic [2:0] S_T_STATUS = 3'd4;
    localparam logic [2:0] S_T_JUMP   = 3'd5;
    localparam logic [2:0] S_R_STATUS = 3'd6;
    localparam logic [2:0] S_R_JUMP   = 3'd7;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_UEPC    = 12'h041;
    localparam logic [11:0] CSR_UCAUSE  = 12'h042;
    localparam logic [11:0] CSR_UTVAL   = 12'h043;

    localparam int MSTATUS_UIE    = 0;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_UPIE   = 4;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRV_M = 2'b11;
    localparam logic [1:0] PRV_U = 2'b00;

endpackage

// File: rtl/aftab_trap_vector.sv
// Trap vector computation from tvec and cause.
// Vectored mode is only built when AFTAB_TRAP_VECTORED_EN is defined; otherwise direct mode only.
module aftab_trap_vector
    import aftab_trap_pkg::*;
#(
    parameter int LEN = TRAP_LEN
) (
    input  logic [LEN-1:0] i_tvec,
    input  logic [LEN-1:0] i_cause,
    output logic [LEN-1:0] o_vector
);

    logic [LEN-1:0] w_base;
    assign w_base = {i_tvec[LEN-1:2], 2'b00};

`ifdef AFTAB_TRAP_VECTORED_EN
    // Only interrupts (cause MSB set) are dispatched through the vector table.
    logic [LEN-1:0] w_offset;
    logic           w_vectored;
    logic           w_unusedCause;
    assign w_offset      = {{(LEN-7){1'b0}}, i_cause[4:0], 2'b00};
    assign w_vectored    = (i_tvec[1:0] == 2'b01) && i_cause[LEN-1];
    assign o_vector      = w_vectored ? (w_base + w_offset) : w_base;
    assign w_unusedCause = ^i_cause[LEN-2:5];
`else
    logic w_unusedBits;
    assign o_vector     = w_base;
    assign w_unusedBits = ^{i_tvec[1:0], i_cause};
`endif

endmodule

// File: rtl/aftab_trap_seq.sv
// Trap entry / mret / uret sequencer: writes xepc, xcause, xtval, mstatus and redirects the PC.
// Vectored trap mode is enabled by defining AFTAB_TRAP_VECTORED_EN.
module aftab_trap_seq
    import aftab_trap_pkg::*;
#(
    parameter int LEN = TRAP_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_interruptRaise,
    input  logic           i_exceptionRaise,
    input  logic           i_instrDone,
    input  logic           i_mretReq,
    input  logic           i_uretReq,
    input  logic [LEN-1:0] i_causeCode,
    input  logic [LEN-1:0] i_trapValue,
    input  logic [1:0]     i_delegationMode,
    input  logic [1:0]     i_curPRV,
    input  logic [LEN-1:0] i_outPC,
    input  logic [LEN-1:0] i_mtvecCSR,
    input  logic [LEN-1:0] i_utvecCSR,
    input  logic [LEN-1:0] i_mepcCSR,
    input  logic [LEN-1:0] i_uepcCSR,
    input  logic [LEN-1:0] i_mstatusCSR,
    output logic           o_ldDelegation,
    output logic           o_ldMachine,
    output logic           o_ldUser,
    output logic           o_csrWrEn,
    output logic [11:0]    o_csrWrAddr,
    output logic [LEN-1:0] o_csrWrData,
    output logic           o_pcLoad,
    output logic [LEN-1:0] o_pcTarget,
    output logic           o_busy,
    output logic           o_trapTaken
);

    logic [2:0]     r_state;
    logic [LEN-1:0] r_cause;
    logic [LEN-1:0] r_tval;
    logic [LEN-1:0] r_pc;
    logic [1:0]     r_mode;
    logic           r_isMret;
    logic [1:0]     r_mpp;

    logic           w_idle;
    logic           w_trapAccept;
    logic           w_mretAccept;
    logic           w_uretAccept;
    logic [1:0]     w_mode;
    logic           w_isMachine;
    logic [LEN-1:0] w_tvec;
    logic [LEN-1:0] w_vector;
    logic [LEN-1:0] w_trapStatus;
    logic [LEN-1:0] w_retStatus;

    assign w_idle       = (r_state == S_IDLE);
    assign w_trapAccept = w_idle && (i_exceptionRaise || (i_interruptRaise && i_instrDone));
    assign w_mretAccept = w_idle && !w_trapAccept && i_mretReq;
    assign w_uretAccept = w_idle && !w_trapAccept && !i_mretReq && i_uretReq;

    // The detector's delegation register is valid from T_EPC on; it is held locally afterwards.
    assign w_mode      = (r_state == S_T_EPC) ? i_delegationMode : r_mode;
    assign w_isMachine = (w_mode == PRV_M);
    assign w_tvec      = w_isMachine ? i_mtvecCSR : i_utvecCSR;

    aftab_trap_vector #(.LEN(LEN)) u_vector (
        .i_tvec   (w_tvec),
        .i_cause  (r_cause),
        .o_vector (w_vector)
    );

    always_comb begin
        w_trapStatus = i_mstatusCSR;
        w_retStatus  = i_mstatusCSR;
        if (w_isMachine) begin
            w_trapStatus[MSTATUS_MPIE]                  = i_mstatusCSR[MSTATUS_MIE];
            w_trapStatus[MSTATUS_MIE]                   = 1'b0;
            w_trapStatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = i_curPRV;
        end else begin
            w_trapStatus[MSTATUS_UPIE] = i_mstatusCSR[MSTATUS_UIE];
            w_trapStatus[MSTATUS_UIE]  = 1'b0;
        end
        if (r_isMret) begin
            w_retStatus[MSTATUS_MIE]                   = i_mstatusCSR[MSTATUS_MPIE];
            w_retStatus[MSTATUS_MPIE]                  = 1'b1;
            w_retStatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_U;
        end else begin
            w_retStatus[MSTATUS_UIE]  = i_mstatusCSR[MSTATUS_UPIE];
            w_retStatus[MSTATUS_UPIE] = 1'b1;
        end
    end

    assign o_ldDelegation = w_trapAccept && !rst;
    assign o_busy         = !w_idle;
    assign o_trapTaken    = (r_state == S_T_JUMP);

    always_comb begin
        o_csrWrEn   = 1'b0;
        o_csrWrAddr = 12'h000;
        o_csrWrData = '0;
        o_pcLoad    = 1'b0;
        o_pcTarget  = '0;
        o_ldMachine = 1'b0;
        o_ldUser    = 1'b0;
        case (r_state)
            S_T_EPC: begin
                o_csrWrEn   = 1'b1;
                o_csrWrAddr = w_isMachine ? CSR_MEPC : CSR_UEPC;
                o_csrWrData = r_pc;
            end
            S_T_CAUSE: begin
                o_csrWrEn   = 1'b1;
                o_csrWrAddr = w_isMachine ? CSR_MCAUSE : CSR_UCAUSE;
                o_csrWrData = r_cause;
            end
            S_T_TVAL: begin
                o_csrWrEn   = 1'b1;
                o_csrWrAddr = w_isMachine ? CSR_MTVAL : CSR_UTVAL;
                o_csrWrData = r_tval;
            end
            S_T_STATUS: begin
                o_csrWrEn   = 1'b1;
                o_csrWrAddr = CSR_MSTATUS;
                o_csrWrData = w_trapStatus;
            end
            S_T_JUMP: begin
                o_pcLoad    = 1'b1;
                o_pcTarget  = w_vector;
                o_ldMachine = w_isMachine;
                o_ldUser    = !w_isMachine;
            end
            S_R_STATUS: begin
                o_csrWrEn   = 1'b1;
                o_csrWrAddr = CSR_MSTATUS;
                o_csrWrData = w_retStatus;
            end
            S_R_JUMP: begin
                o_pcLoad    = 1'b1;
                o_pcTarget  = r_isMret ? i_mepcCSR : i_uepcCSR;
                o_ldMachine = r_isMret && (r_mpp == PRV_M);
                o_ldUser    = !(r_isMret && (r_mpp == PRV_M));
            end
            default: ;
        endcase
    end

    // Sequencer state plus the trap context captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cause  <= '0;
            r_tval   <= '0;
            r_pc     <= '0;
            r_mode   <= 2'b00;
            r_isMret <= 1'b0;
            r_mpp    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trapAccept) begin
                        r_cause <= i_causeCode;
                        r_tval  <= i_trapValue;
                        r_pc    <= i_outPC;
                        r_state <= S_T_EPC;
                    end else if (w_mretAccept) begin
                        r_isMret <= 1'b1;
                        r_state  <= S_R_STATUS;
                    end else if (w_uretAccept) begin
                        r_isMret <= 1'b0;
                        r_state  <= S_R_STATUS;
                    end
                end
                S_T_EPC: begin
                    r_mode  <= i_delegationMode;
                    r_state <= S_T_CAUSE;
                end
                S_T_CAUSE:  r_state <= S_T_TVAL;
                S_T_TVAL:   r_state <= S_T_STATUS;
                S_T_STATUS: r_state <= S_T_JUMP;
                S_T_JUMP:   r_state <= S_IDLE;
                S_R_STATUS: begin
                    r_mpp   <= i_mstatusCSR[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                    r_state <= S_R_JUMP;
                end
                S_R_JUMP:   r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_trap_seq.sv
// Directed self-checking bench for aftab_trap_seq; expectations follow AFTAB_TRAP_VECTORED_EN.
module tb_aftab_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        interruptRaise, exceptionRaise, instrDone, mretReq, uretReq;
    logic [31:0] causeCode, trapValue, outPC;
    logic [31:0] mtvecCSR, utvecCSR, mepcCSR, uepcCSR, mstatusCSR;
    logic [1:0]  delegationMode, curPRV;
    logic        ldDelegation, ldMachine, ldUser, csrWrEn, pcLoad, busy, trapTaken;
    logic [11:0] csrWrAddr;
    logic [31:0] csrWrData, pcTarget;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aftab_trap_seq #(.LEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_interruptRaise (interruptRaise),
        .i_exceptionRaise (exceptionRaise),
        .i_instrDone      (instrDone),
        .i_mretReq        (mretReq),
        .i_uretReq        (uretReq),
        .i_causeCode      (causeCode),
        .i_trapValue      (trapValue),
        .i_delegationMode (delegationMode),
        .i_curPRV         (curPRV),
        .i_outPC          (outPC),
        .i_mtvecCSR       (mtvecCSR),
        .i_utvecCSR       (utvecCSR),
        .i_mepcCSR        (mepcCSR),
        .i_uepcCSR        (uepcCSR),
        .i_mstatusCSR     (mstatusCSR),
        .o_ldDelegation   (ldDelegation),
        .o_ldMachine      (ldMachine),
        .o_ldUser         (ldUser),
        .o_csrWrEn        (csrWrEn),
        .o_csrWrAddr      (csrWrAddr),
        .o_csrWrData      (csrWrData),
        .o_pcLoad         (pcLoad),
        .o_pcTarget       (pcTarget),
        .o_busy           (busy),
        .o_trapTaken      (trapTaken)
    );

    task automatic test_reset();
        rst = 1'b1;
        interruptRaise = 0; exceptionRaise = 1; instrDone = 0; mretReq = 0; uretReq = 0;
        causeCode = 0; trapValue = 0; outPC = 0; mtvecCSR = 0; utvecCSR = 0;
        mepcCSR = 0; uepcCSR = 0; mstatusCSR = 0; delegationMode = 2'b11; curPRV = 2'b11;
        repeat (2) @(negedge clk);
        checks++;
        if ({ldDelegation, ldMachine, ldUser, csrWrEn, csrWrAddr, csrWrData, pcLoad, pcTarget, busy, trapTaken} !== 83'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got en=%b addr=%h data=%h pc=%b tgt=%h busy=%b ldDel=%b expected all 0",
                     csrWrEn, csrWrAddr, csrWrData, pcLoad, pcTarget, busy, ldDelegation);
        end
        exceptionRaise = 0;
        rst = 1'b0;
    endtask

    task automatic test_machine_exception();
        logic [11:0] ea[4];
        logic [31:0] ed[4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h40, 32'h2, 32'h00A0_0013, 32'h0000_1880};
        @(negedge clk);
        mtvecCSR = 32'h100; mstatusCSR = 32'h8; curPRV = 2'b11; delegationMode = 2'b11;
        causeCode = 32'd2; trapValue = 32'h00A0_0013; outPC = 32'h40; exceptionRaise = 1;
        #1;
        checks++;
        if ({ldDelegation, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL mexc_accept: got ldDel=%b busy=%b expected ldDel=1 busy=0", ldDelegation, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exceptionRaise = 0;
            checks++;
            if ({busy, csrWrEn, csrWrAddr, csrWrData, pcLoad} !== {1'b1, 1'b1, ea[k], ed[k], 1'b0}) begin
                errors++;
                $display("[TB] FAIL mexc_write%0d: got en=%b addr=%h data=%h expected addr=%h data=%h",
                         k, csrWrEn, csrWrAddr, csrWrData, ea[k], ed[k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({pcLoad, pcTarget, trapTaken, ldMachine, ldUser, csrWrEn} !== {1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mexc_jump: got pcLoad=%b tgt=%h taken=%b ldM=%b ldU=%b expected 1 00000100 1 1 0",
                     pcLoad, pcTarget, trapTaken, ldMachine, ldUser);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mexc_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_vectored_interrupt();
        logic [31:0] expTarget;
`ifdef AFTAB_TRAP_VECTORED_EN
        expTarget = 32'h21C;
`else
        expTarget = 32'h200;
`endif
        mtvecCSR = 32'h201; causeCode = 32'h8000_0007; trapValue = 0; outPC = 32'h44;
        delegationMode = 2'b11; curPRV = 2'b00; mstatusCSR = 32'h8;
        interruptRaise = 1; instrDone = 0;
        #1;
        checks++;
        if (ldDelegation !== 1'b0) begin
            errors++;
            $display("[TB] FAIL int_no_boundary: got ldDel=%b expected 0", ldDelegation);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL int_no_boundary_busy: got busy=%b expected 0", busy);
        end
        instrDone = 1;
        #1;
        checks++;
        if (ldDelegation !== 1'b1) begin
            errors++;
            $display("[TB] FAIL int_accept: got ldDel=%b expected 1", ldDelegation);
        end
        @(negedge clk);
        interruptRaise = 0; instrDone = 0;
        checks++;
        if ({busy, csrWrEn, csrWrAddr, csrWrData} !== {1'b1, 1'b1, 12'h341, 32'h44}) begin
            errors++;
            $display("[TB] FAIL int_epc: got busy=%b addr=%h data=%h expected 341 00000044", busy, csrWrAddr, csrWrData);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({csrWrAddr, csrWrData} !== {12'h300, 32'h80}) begin
            errors++;
            $display("[TB] FAIL int_status: got addr=%h data=%h expected 300 00000080", csrWrAddr, csrWrData);
        end
        @(negedge clk);
        checks++;
        if ({pcLoad, pcTarget, ldMachine} !== {1'b1, expTarget, 1'b1}) begin
            errors++;
            $display("[TB] FAIL int_vector: got pcLoad=%b tgt=%h ldM=%b expected 1 %h 1", pcLoad, pcTarget, ldMachine, expTarget);
        end
        @(negedge clk);
    endtask

    task automatic test_user_ecall();
        logic [11:0] ea[4];
        logic [31:0] ed[4];
        ea = '{12'h041, 12'h042, 12'h043, 12'h300};
        ed = '{32'h1000, 32'h8, 32'h0, 32'h18};
        mtvecCSR = 32'h300; utvecCSR = 32'h405; mstatusCSR = 32'h9;
        delegationMode = 2'b00; curPRV = 2'b00;
        causeCode = 32'd8; trapValue = 0; outPC = 32'h1000; exceptionRaise = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exceptionRaise = 0;
            checks++;
            if ({busy, csrWrEn, csrWrAddr, csrWrData} !== {1'b1, 1'b1, ea[k], ed[k]}) begin
                errors++;
                $display("[TB] FAIL uecall_write%0d: got en=%b addr=%h data=%h expected addr=%h data=%h",
                         k, csrWrEn, csrWrAddr, csrWrData, ea[k], ed[k]);
            end
            if (k == 1) delegationMode = 2'b11;
        end
        @(negedge clk);
        checks++;
        if ({pcLoad, pcTarget, trapTaken, ldMachine, ldUser} !== {1'b1, 32'h404, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL uecall_jump: got pcLoad=%b tgt=%h taken=%b ldM=%b ldU=%b expected 1 00000404 1 0 1",
                     pcLoad, pcTarget, trapTaken, ldMachine, ldUser);
        end
        @(negedge clk);
        delegationMode = 2'b11;
    endtask

    task automatic test_returns();
        logic        isMret[3];
        logic [31:0] st[3], epc[3], expData[3];
        logic        expM[3];
        isMret = '{1'b1, 1'b1, 1'b0};
        st      = '{32'h80, 32'h1880, 32'h10};
        epc     = '{32'h80, 32'h2000, 32'h3000};
        expData = '{32'h88, 32'h88, 32'h11};
        expM    = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            mstatusCSR = st[k];
            mepcCSR = isMret[k] ? epc[k] : 32'hDEAD_0000;
            uepcCSR = isMret[k] ? 32'hBEEF_0000 : epc[k];
            mretReq = isMret[k]; uretReq = !isMret[k];
            #1;
            checks++;
            if ({ldDelegation, busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL ret%0d_accept: got ldDel=%b busy=%b expected 0 0", k, ldDelegation, busy);
            end
            @(negedge clk);
            mretReq = 0; uretReq = 0;
            checks++;
            if ({busy, csrWrEn, csrWrAddr, csrWrData, pcLoad} !== {1'b1, 1'b1, 12'h300, expData[k], 1'b0}) begin
                errors++;
                $display("[TB] FAIL ret%0d_status: got en=%b addr=%h data=%h expected 300 %h", k, csrWrEn, csrWrAddr, csrWrData, expData[k]);
            end
            @(negedge clk);
            checks++;
            if ({pcLoad, pcTarget, ldMachine, ldUser, trapTaken, csrWrEn} !== {1'b1, epc[k], expM[k], !expM[k], 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL ret%0d_jump: got pcLoad=%b tgt=%h ldM=%b ldU=%b taken=%b expected tgt=%h ldM=%b",
                         k, pcLoad, pcTarget, ldMachine, ldUser, trapTaken, epc[k], expM[k]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ret%0d_idle: got busy=%b expected 0", k, busy);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        mtvecCSR = 32'h100; mstatusCSR = 32'h8; delegationMode = 2'b11; curPRV = 2'b11;
        causeCode = 32'd5; trapValue = 32'h77; outPC = 32'h500; exceptionRaise = 1;
        @(negedge clk);
        exceptionRaise = 0;
        @(negedge clk);
        checks++;
        if ({busy, csrWrAddr, csrWrData} !== {1'b1, 12'h342, 32'd5}) begin
            errors++;
            $display("[TB] FAIL rstmid_cause: got busy=%b addr=%h data=%h expected 1 342 00000005", busy, csrWrAddr, csrWrData);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ldDelegation, ldMachine, ldUser, csrWrEn, csrWrAddr, csrWrData, pcLoad, pcTarget, busy, trapTaken} !== 83'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got en=%b addr=%h data=%h pc=%b busy=%b expected all 0",
                     csrWrEn, csrWrAddr, csrWrData, pcLoad, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({pcLoad, busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rstmid_quiet%0d: got pcLoad=%b busy=%b expected 0 0", k, pcLoad, busy);
            end
        end
    endtask

    task automatic test_exception_with_mret();
        mtvecCSR = 32'h100; mstatusCSR = 32'h80; mepcCSR = 32'h80;
        causeCode = 32'd2; trapValue = 0; outPC = 32'h600;
        exceptionRaise = 1; mretReq = 1;
        #1;
        checks++;
        if (ldDelegation !== 1'b1) begin
            errors++;
            $display("[TB] FAIL excmret_accept: got ldDel=%b expected 1", ldDelegation);
        end
        @(negedge clk);
        exceptionRaise = 0; mretReq = 0;
        checks++;
        if ({csrWrAddr, csrWrData} !== {12'h341, 32'h600}) begin
            errors++;
            $display("[TB] FAIL excmret_epc: got addr=%h data=%h expected 341 00000600", csrWrAddr, csrWrData);
        end
        @(negedge clk);
        checks++;
        if (pcLoad !== 1'b0) begin
            errors++;
            $display("[TB] FAIL excmret_nojump: got pcLoad=%b expected 0", pcLoad);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({pcLoad, trapTaken, pcTarget} !== {1'b1, 1'b1, 32'h100}) begin
            errors++;
            $display("[TB] FAIL excmret_jump: got pcLoad=%b taken=%b tgt=%h expected 1 1 00000100", pcLoad, trapTaken, pcTarget);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mtvecCSR = 32'h100; mstatusCSR = 32'h8; delegationMode = 2'b11; curPRV = 2'b11;
        causeCode = 32'd3; trapValue = 0; outPC = 32'h700; exceptionRaise = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({ldDelegation, busy} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL b2b_ignore%0d: got ldDel=%b busy=%b expected 0 1", k, ldDelegation, busy);
            end
        end
        @(negedge clk);
        checks++;
        if ({ldDelegation, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_reaccept: got ldDel=%b busy=%b expected 1 0", ldDelegation, busy);
        end
        outPC = 32'h704;
        @(negedge clk);
        exceptionRaise = 0;
        checks++;
        if ({busy, csrWrAddr, csrWrData} !== {1'b1, 12'h341, 32'h704}) begin
            errors++;
            $display("[TB] FAIL b2b_second_epc: got busy=%b addr=%h data=%h expected 1 341 00000704", busy, csrWrAddr, csrWrData);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_machine_exception();
        test_vectored_interrupt();
        test_user_ecall();
        test_returns();
        test_reset_mid_sequence();
        test_exception_with_mret();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
